// File: rtl/sw_input_port.sv
// Board switch input port: 2-flop synchronizer, tick-sampled debouncer, and an LSU
// register block (DEB/CHG/MASK). Optional edge interrupt output under SW_EDGE_IRQ_EN.
//
// LSU access: a store takes effect on the rising edge where i_sel && i_lsu_wren.
// o_ld_data is combinational from i_lsu_addr[3:2] and does not depend on i_sel.
module sw_input_port #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_io_sw,
  input  logic [3:0]  i_lsu_addr,
  input  logic        i_lsu_wren,
  input  logic        i_sel,
  input  logic [31:0] i_st_data,
  output logic [31:0] o_ld_data,
  output logic        o_irq
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] A_DEB  = 2'd0;
  localparam logic [1:0] A_CHG  = 2'd1;
  localparam logic [1:0] A_MASK = 2'd2;

  logic [31:0]   sync1_q, sync2_q;
  logic [31:0]   prev_q, prev_d;
  logic [31:0]   deb_q, deb_d;
  logic [31:0]   chg_q, chg_d;
  logic [31:0]   mask_q, mask_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;
  logic          wr_en;
  logic [1:0]    reg_sel;
  logic [31:0]   stable;
  logic          unused_addr;

  assign reg_sel     = i_lsu_addr[3:2];
  assign unused_addr = ^i_lsu_addr[1:0];
  assign wr_en       = i_sel & i_lsu_wren;
  assign tick        = (cnt_q == TERM);
  assign stable      = ~(sync2_q ^ prev_q);

  always_comb begin
    cnt_d  = tick ? '0 : cnt_q + 1'b1;
    prev_d = prev_q;
    deb_d  = deb_q;
    if (tick) begin
      prev_d = sync2_q;
      // Only bits seen at the same level on two consecutive ticks move.
      deb_d  = (deb_q & ~stable) | (sync2_q & stable);
    end
  end

  always_comb begin
    mask_d = mask_q;
    chg_d  = chg_q;
    if (wr_en && reg_sel == A_MASK) mask_d = i_st_data;
    if (wr_en && reg_sel == A_CHG)  chg_d  = chg_q & ~i_st_data;
    // Set is applied after the clear so a coincident edge keeps the flag.
    chg_d = chg_d | ((deb_d ^ deb_q) & mask_q);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      deb_q   <= '0;
      chg_q   <= '0;
      mask_q  <= '1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= i_io_sw;
      sync2_q <= sync1_q;
      prev_q  <= prev_d;
      deb_q   <= deb_d;
      chg_q   <= chg_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    o_ld_data = 32'h0;
    case (reg_sel)
      A_DEB:   o_ld_data = deb_q;
      A_CHG:   o_ld_data = chg_q;
      A_MASK:  o_ld_data = mask_q;
      default: o_ld_data = 32'h0;
    endcase
  end

`ifdef SW_EDGE_IRQ_EN
  logic irq_q, irq_d;

  assign irq_d = |chg_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end

  assign o_irq = irq_q;
`else
  assign o_irq = 1'b0;
`endif

endmodule
